// File: rtl/bank_capture.sv
// bank_capture: triggered logic-capture engine.
// Samples four 8-bit input banks every cycle. Once armed, it waits for a
// masked trigger match and then writes DEPTH = 2**ADDR_W samples into a RAM
// write port, one every div+1 cycles. It then flags done.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   arm, abort          single-cycle control pulses (abort wins over arm)
//   div                 sample period minus one
//   trig_mask/value     masked trigger compare on the sampled word
//   bank0..bank3        sampled inputs; bank0 -> bits [7:0]
//   mem_addr/data/we    RAM write port; word 0 carries trigger marker bit 32
//   busy, done, count   status; count = words written in current/last run
module bank_capture #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [DIV_W-1:0]  div,
  input  logic [31:0]       trig_mask,
  input  logic [31:0]       trig_value,
  input  logic [7:0]        bank0,
  input  logic [7:0]        bank1,
  input  logic [7:0]        bank2,
  input  logic [7:0]        bank3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [35:0]       mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       s_q;
  logic [DIV_W-1:0]  div_cnt;
  logic              match_c;

  // Masked trigger compare on the registered sample
  assign match_c = ((s_q ^ trig_value) & trig_mask) == 32'd0;

  // Capture FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s_q      <= '0;
      div_cnt  <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      s_q    <= {bank3, bank2, bank1, bank0};
      mem_we <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
        div_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state <= ARMED;
              busy  <= 1'b1;
              count <= '0;
            end
          end
          ARMED: begin
            // Word 0 carries the trigger marker in bit 32
            if (match_c) begin
              state    <= CAPTURE;
              mem_we   <= 1'b1;
              mem_addr <= '0;
              mem_data <= {4'b0001, s_q};
              count    <= CNT_W'(1);
              div_cnt  <= '0;
            end
          end
          CAPTURE: begin
            // count reaches DEPTH with the write to DEPTH-1 visible; stop next
            if (count == CNT_W'(DEPTH)) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              div_cnt <= '0;
            end else if (div_cnt == div) begin
              div_cnt  <= '0;
              mem_we   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
              mem_data <= {4'b0000, s_q};
              count    <= count + CNT_W'(1);
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          DONE: begin
            if (arm) begin
              state <= ARMED;
              busy  <= 1'b1;
              done  <= 1'b0;
              count <= '0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/bank_capture.md
Name: bank_capture

Overview:
- Input-side counterpart of the PROM-driven bank pattern generator: samples four 8-bit input banks and writes them as 36-bit words into a 128-entry RAM write port.
- Acts as a small triggered logic-capture engine.
- Software or a test harness arms it, it waits for a masked trigger match, then stores DEPTH samples at a programmable rate and flags done.

Parameters:
- ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W words captured per run.
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- arm  in  1  single-cycle pulse; start a capture run.
- abort  in  1  single-cycle pulse; cancel the run, return to IDLE.
- div  in  DIV_W  sample period minus one; one sample every div+1 cycles.
- trig_mask  in  32  1 = bit participates in the trigger compare.
- trig_value  in  32  trigger pattern.
- bank0..bank3  in  8 each  sampled inputs; bank0 = word bits [7:0], bank3 = bits [31:24].
- mem_addr  out  ADDR_W  RAM write address.
- mem_data  out  36  RAM write data.
- mem_we  out  1  RAM write enable, one cycle per word.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- count  out  ADDR_W+1  number of words written in the current or last run.

Behaviour:
- Reset (async, immediate): state IDLE; mem_addr 0, mem_data 0, mem_we 0, busy 0, done 0, count 0; sample register s_q 0; divider 0.
- Sampling: s_q <= {bank3, bank2, bank1, bank0} every cycle in all states. No further synchronisation is applied; the inputs are assumed board-synchronous.
- Match: match = (((s_q ^ trig_value) & trig_mask) == 0). A mask of 0 triggers on the first cycle in ARMED.
- IDLE:
  - arm -> ARMED; count <= 0.
- ARMED:
  - match evaluated every cycle.
  - On match -> CAPTURE; in the next cycle mem_we=1, mem_addr=0, mem_data={4'b0001, matched s_q}; count=1; divider cleared to 0.
  - Bit 32 is the trigger marker and is set only on word 0.
- CAPTURE:
  - Divider counts 0..div and wraps.
  - Each wrap (div+1 cycles after the previous write) issues one write of {4'b0000, s_q}, then mem_addr+1 and count+1.
  - div=0 gives back-to-back writes every cycle.
  - div is sampled live; changing it mid-run is undefined.
  - The write to address DEPTH-1 completes the run. The next cycle is DONE: mem_we=0, count=DEPTH, mem_addr holds DEPTH-1.
- DONE:
  - done=1 and held.
  - arm -> ARMED, clears done and count.
- mem_we:
  - Never high for more than one cycle unless div=0.
  - Never high outside the cycles listed above.
  - mem_data and mem_addr are only valid when mem_we=1.
- abort:
  - From any state -> IDLE next cycle; mem_we forced 0 that cycle.
  - count retains the words already written.
- Simultaneous events:
  - abort and arm in the same cycle: abort wins.
  - arm in ARMED or CAPTURE is ignored.
  - match in IDLE or DONE is ignored.
- Reset mid-run: outputs return immediately to reset values; RAM contents are not touched.
- No address wrap: the engine never writes past DEPTH-1.

Test Plan:
- Reset: assert rst mid-CAPTURE -> mem_we, busy, done, count all 0 immediately; state IDLE; the next arm works normally.
- Immediate trigger:
  - Stimulus: trig_mask=0, div=0, banks driven by an incrementing 32-bit counter, arm.
  - Required: 128 consecutive writes, addresses 0..127, word 0 bit 32 = 1, data increments by 1 per word.
  - Then done=1, count=128.
- Pattern trigger:
  - Stimulus: trig_mask=0x000000FF, trig_value=0x000000A5, bank0 ramps 0..255.
  - Required: no write until s_q[7:0]=0xA5; word 0 = 0x1_xxxxxxA5.
- Divider: div=3 -> exactly 4 cycles between successive mem_we pulses; total run length 1 + 127*4 cycles after the first write.
- Abort:
  - Stimulus: abort after the 10th write.
  - Required: IDLE, busy=0, done=0, count=10, no further writes.
  - Abort and arm in the same cycle -> stays IDLE.
- Re-arm from DONE: arm -> done drops next cycle, count=0, the second run overwrites from address 0; arm pulses during CAPTURE have no effect.
